// File: rtl/lfsr_dds_pkg.sv
// Shared defaults, LFSR tap positions and seed helper for the LFSR DDS tick generator.
package lfsr_dds_pkg;

   localparam int unsigned ACC_WIDTH_DEF  = 32;
   localparam int unsigned LFSR_WIDTH_DEF = 22;

   // x^22 + x^21 + 1 expressed as register bit positions
   localparam int unsigned TAP_HI = 21;
   localparam int unsigned TAP_LO = 20;

   localparam logic [LFSR_WIDTH_DEF-1:0] DEFAULT_SEED = 22'h000001;

   // An all-zero LFSR would lock up, so a zero seed becomes 1.
   function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
      return (s == '0) ? 32'd1 : s;
   endfunction

endpackage

// File: rtl/lfsr_dds_phase_acc.sv
// DDS phase accumulator; tick flags the cycle whose enabled update carries out of the MSB.
module lfsr_dds_phase_acc
   import lfsr_dds_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [ACC_WIDTH-1:0] increment,
   output logic                 tick
);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH:0]   sum;

   always_comb begin
      sum = {1'b0, acc} + {1'b0, increment};
   end

   assign tick = enable & sum[ACC_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (enable) begin
         acc <= sum[ACC_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/lfsr_dds_gen.sv
// LFSR clocked by DDS carry ticks, with tick interrupt to the Nios system.
// Define LFSR_DDS_STICKY_IRQ_EN for an interrupt that holds until irq_ack.
module lfsr_dds_gen
   import lfsr_dds_pkg::*;
#(
   parameter int unsigned          ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int unsigned          LFSR_WIDTH = LFSR_WIDTH_DEF,
   parameter logic [LFSR_WIDTH-1:0] RESET_SEED = DEFAULT_SEED
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ACC_WIDTH-1:0]  dds_increment,
   input  logic                  lfsr_enable,
   input  logic                  lfsr_seed_load,
   input  logic [LFSR_WIDTH-1:0] lfsr_seed,
   input  logic                  irq_ack,
   output logic [31:0]           lfsr_val,
   output logic                  lfsr_clk_interrupt_gen
);

   localparam logic [LFSR_WIDTH-1:0] SEED_AFTER_RESET =
      LFSR_WIDTH'(nonzero_seed(32'(RESET_SEED)));

   logic                  tick;
   logic                  fb;
   logic                  shift_en;
   logic [LFSR_WIDTH-1:0] q;

   lfsr_dds_phase_acc #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_phase (
      .clk       (clk),
      .rst       (reset),
      .enable    (lfsr_enable),
      .increment (dds_increment),
      .tick      (tick)
   );

   assign fb       = q[TAP_HI] ^ q[TAP_LO];
   // A seed load in the same cycle as a tick suppresses both shift and interrupt.
   assign shift_en = tick & ~lfsr_seed_load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= SEED_AFTER_RESET;
      end else if (lfsr_seed_load) begin
         q <= LFSR_WIDTH'(nonzero_seed(32'(lfsr_seed)));
      end else if (shift_en) begin
         q <= {q[LFSR_WIDTH-2:0], fb};
      end
   end

   assign lfsr_val = 32'(q);

`ifdef LFSR_DDS_STICKY_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_clk_interrupt_gen <= 1'b0;
      end else if (shift_en) begin
         lfsr_clk_interrupt_gen <= 1'b1;
      end else if (irq_ack) begin
         lfsr_clk_interrupt_gen <= 1'b0;
      end
   end
`else
   logic unused_ack;
   assign unused_ack = irq_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_clk_interrupt_gen <= 1'b0;
      end else begin
         lfsr_clk_interrupt_gen <= shift_en;
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_dds_gen.sv
// Self-checking bench for lfsr_dds_gen: arithmetic reference model plus directed literal checks.
module tb_lfsr_dds_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dds_increment;
   logic        lfsr_enable;
   logic        lfsr_seed_load;
   logic [21:0] lfsr_seed;
   logic        irq_ack;
   logic [31:0] lfsr_val;
   logic        lfsr_clk_interrupt_gen;

   int vectors     = 0;
   int miscompares = 0;

   lfsr_dds_gen dut (
      .clk                    (clk),
      .reset                  (reset),
      .dds_increment          (dds_increment),
      .lfsr_enable            (lfsr_enable),
      .lfsr_seed_load         (lfsr_seed_load),
      .lfsr_seed              (lfsr_seed),
      .irq_ack                (irq_ack),
      .lfsr_val               (lfsr_val),
      .lfsr_clk_interrupt_gen (lfsr_clk_interrupt_gen)
   );

   always #5 clk = ~clk;

   // Reference model: phase as an integer modulo 2^32, tick when the sum reaches 2^32.
   longint unsigned m_acc;
   int unsigned     m_lfsr;
   bit              m_irq;
   bit              m_tick;

   function automatic int unsigned lfsr_next(input int unsigned v);
      int unsigned fbit;
      fbit = ((v >> 21) ^ (v >> 20)) & 1;
      return ((v << 1) & 32'h003F_FFFF) | fbit;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_acc  = 0;
         m_lfsr = 1;
         m_irq  = 0;
      end else begin
         m_tick = lfsr_enable && ((m_acc + 64'(dds_increment)) >= 64'h1_0000_0000);
         if (lfsr_enable) m_acc = (m_acc + 64'(dds_increment)) % 64'h1_0000_0000;
         if (lfsr_seed_load) m_lfsr = (lfsr_seed == 0) ? 1 : 32'(lfsr_seed);
         else if (m_tick)    m_lfsr = lfsr_next(m_lfsr);
`ifdef LFSR_DDS_STICKY_IRQ_EN
         if (m_tick && !lfsr_seed_load) m_irq = 1;
         else if (irq_ack)              m_irq = 0;
`else
         m_irq = m_tick && !lfsr_seed_load;
`endif
      end
   end

   always @(negedge clk) begin
      vectors++;
      if (lfsr_val !== m_lfsr || lfsr_clk_interrupt_gen !== m_irq ||
          64'(dut.u_phase.acc) !== m_acc) begin
         miscompares++;
         $display("FAIL cycle t=%0t: lfsr_val=%h irq=%b acc=%h, required lfsr_val=%h irq=%b acc=%h",
                  $time, lfsr_val, lfsr_clk_interrupt_gen, dut.u_phase.acc, m_lfsr, m_irq, m_acc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [31:0] inc;
      logic        en;
      logic        load;
      logic [21:0] seed;
      logic        ack;
      int          n;
   } vec_t;

   vec_t table_v[$] = '{
      '{32'h9000_0000, 1'b1, 1'b0, 22'h0,      1'b0, 5},
      '{32'h9000_0000, 1'b0, 1'b0, 22'h0,      1'b0, 3},
      '{32'h1234_5678, 1'b1, 1'b0, 22'h0,      1'b1, 9},
      '{32'h8000_0001, 1'b1, 1'b1, 22'h2AAAAA, 1'b0, 1},
      '{32'h8000_0001, 1'b1, 1'b0, 22'h0,      1'b0, 8},
      '{32'hC000_0000, 1'b0, 1'b1, 22'h0,      1'b0, 1},
      '{32'hFFFF_FFFF, 1'b1, 1'b0, 22'h0,      1'b1, 6},
      '{32'h0000_0000, 1'b1, 1'b0, 22'h0,      1'b0, 4}
   };

   int highs;

   initial begin
      reset = 1'b1; dds_increment = '0; lfsr_enable = 1'b0;
      lfsr_seed_load = 1'b0; lfsr_seed = '0; irq_ack = 1'b0;
      cyc(2);
      chk("rst_lfsr", lfsr_val, 32'h1);
      chk("rst_irq", 32'(lfsr_clk_interrupt_gen), 32'h0);

      // quarter-turn increment: tick on every 4th enabled cycle
      reset = 1'b0; lfsr_enable = 1'b1; dds_increment = 32'h4000_0000;
      cyc(3);
      chk("q_pre_lfsr", lfsr_val, 32'h1);
`ifndef LFSR_DDS_STICKY_IRQ_EN
      chk("q_pre_irq", 32'(lfsr_clk_interrupt_gen), 32'h0);
`endif
      cyc(1);
      chk("q_t1_lfsr", lfsr_val, 32'h2);
      chk("q_t1_irq", 32'(lfsr_clk_interrupt_gen), 32'h1);
`ifndef LFSR_DDS_STICKY_IRQ_EN
      cyc(1);
      chk("q_t1_irq_drop", 32'(lfsr_clk_interrupt_gen), 32'h0);
      cyc(3);
`else
      cyc(4);
`endif
      chk("q_t2_lfsr", lfsr_val, 32'h4);
      cyc(4);
      chk("q_t3_lfsr", lfsr_val, 32'h8);

      // maximal increment: first cycle no carry, then every cycle
      pulse_reset();
      dds_increment = 32'hFFFF_FFFF;
      cyc(1);
      chk("max_c1_irq", 32'(lfsr_clk_interrupt_gen), 32'h0);
      chk("max_c1_lfsr", lfsr_val, 32'h1);
      cyc(1);
      chk("max_c2_irq", 32'(lfsr_clk_interrupt_gen), 32'h1);
      chk("max_c2_lfsr", lfsr_val, 32'h2);
      cyc(1);
      chk("max_c3_lfsr", lfsr_val, 32'h4);

      // seed loads while frozen, then one shift with fb=0
      pulse_reset();
      lfsr_enable = 1'b0; lfsr_seed_load = 1'b1; lfsr_seed = 22'h0;
      cyc(1);
      chk("seed0_lfsr", lfsr_val, 32'h1);
      lfsr_seed = 22'h30_0000;
      cyc(1);
      lfsr_seed_load = 1'b0;
      chk("seed3_lfsr", lfsr_val, 32'h30_0000);
      lfsr_enable = 1'b1; dds_increment = 32'hFFFF_FFFF;
      cyc(2);
      chk("seed3_shift", lfsr_val, 32'h20_0000);

      // seed load on the same cycle as a tick
      pulse_reset();
      cyc(1);
      lfsr_seed_load = 1'b1; lfsr_seed = 22'h1234;
      cyc(1);
      lfsr_seed_load = 1'b0;
      chk("coll_lfsr", lfsr_val, 32'h1234);
      chk("coll_irq", 32'(lfsr_clk_interrupt_gen), 32'h0);
      chk("coll_acc", dut.u_phase.acc, 32'hFFFF_FFFE);
      dds_increment = 32'h0;
      highs = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(1);
         if (lfsr_clk_interrupt_gen) highs++;
      end
      chk("inc0_irqs", 32'(highs), 32'h0);

      // async reset mid-run with a carry pending
      dds_increment = 32'h0000_0002;
      reset = 1'b1;
      #1;
      chk("arst_lfsr", lfsr_val, 32'h1);
      chk("arst_irq", 32'(lfsr_clk_interrupt_gen), 32'h0);
      chk("arst_acc", dut.u_phase.acc, 32'h0);
      reset = 1'b0;
      cyc(1);
      chk("arst_after_irq", 32'(lfsr_clk_interrupt_gen), 32'h0);

      foreach (table_v[k]) begin
         dds_increment = table_v[k].inc; lfsr_enable = table_v[k].en;
         lfsr_seed_load = table_v[k].load; lfsr_seed = table_v[k].seed;
         irq_ack = table_v[k].ack;
         cyc(table_v[k].n);
      end
      lfsr_seed_load = 1'b0; irq_ack = 1'b0;

`ifdef LFSR_DDS_STICKY_IRQ_EN
      pulse_reset();
      lfsr_enable = 1'b1; dds_increment = 32'hFFFF_FFFF;
      cyc(2);
      dds_increment = 32'h0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (lfsr_clk_interrupt_gen) highs++;
      end
      chk("sticky_hold", 32'(highs), 32'd20);
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      chk("sticky_ack", 32'(lfsr_clk_interrupt_gen), 32'h0);
      dds_increment = 32'h0000_0002; irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0; dds_increment = 32'h0;
      chk("sticky_tick_ack", 32'(lfsr_clk_interrupt_gen), 32'h1);
      cyc(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lfsr_dds_gen.md
LFSR_DDS_GEN -- requirements
Module: lfsr_dds_gen

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: phase accumulator and dds_increment width.
REQ-002 SHALL have parameter LFSR_WIDTH, default 22: LFSR register width, always less than or equal to 32.
REQ-003 SHALL have parameter RESET_SEED, default 22'h000001: LFSR value after reset; a zero value is replaced by 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port dds_increment, input, ACC_WIDTH bits: phase step added every enabled cycle (from the Nios system).
REQ-007 SHALL have port lfsr_enable, input, 1 bit: high runs the accumulator and the LFSR; low freezes both.
REQ-008 SHALL have port lfsr_seed_load, input, 1 bit: one-cycle pulse that loads lfsr_seed.
REQ-009 SHALL have port lfsr_seed, input, LFSR_WIDTH bits: seed value.
REQ-010 SHALL have port irq_ack, input, 1 bit: interrupt acknowledge; used only under REQ-027.
REQ-011 SHALL have port lfsr_val, output, 32 bits: LFSR state zero-extended to 32 bits (to the Nios PIO).
REQ-012 SHALL have port lfsr_clk_interrupt_gen, output, 1 bit: tick/interrupt to the Nios system.

Function
REQ-013 Accumulator: each cycle with lfsr_enable=1, acc <= acc + dds_increment modulo 2^ACC_WIDTH.
REQ-014 Tick: a tick occurs on any enabled cycle where acc + dds_increment carries out of bit ACC_WIDTH-1.
REQ-015 LFSR: Fibonacci form, taps x^22+x^21+1; fb = q[21]^q[20]; on a tick, q <= {q[20:0], fb}.
REQ-016 LFSR timing: the new LFSR value and lfsr_clk_interrupt_gen shall both appear on the same edge that registers the carry, with no combinational input-to-output path.
REQ-017 Interrupt (default mode): lfsr_clk_interrupt_gen shall be high for exactly the one cycle following each tick, and low otherwise.
REQ-018 Seed load: lfsr_seed_load=1 loads lfsr_seed (0 is replaced by 1) regardless of lfsr_enable.
REQ-019 Seed load versus tick: when a seed load and a tick occur in the same cycle, the load wins, the LFSR does not shift, and no interrupt is raised; the accumulator still updates.
REQ-020 Increment changes: take effect on the next cycle; the accumulator is never cleared by a change.
REQ-021 dds_increment=0: no ticks ever occur.
REQ-022 lfsr_enable=0: acc and the LFSR hold, and the default-mode interrupt is low.
REQ-023 Zero state: the LFSR shall never hold 0.

Reset
REQ-024 On reset assertion, acc shall be 0, asynchronously.
REQ-025 On reset assertion, the LFSR shall be RESET_SEED (1 if RESET_SEED is 0), asynchronously.
REQ-026 On reset assertion, lfsr_clk_interrupt_gen shall be 0, asynchronously; a reset mid-run discards any pending tick.

Configuration
REQ-027 With macro LFSR_DDS_STICKY_IRQ_EN defined, lfsr_clk_interrupt_gen shall set on a tick and stay high until a cycle with irq_ack=1; a tick and irq_ack in the same cycle leaves it set; lfsr_enable=0 does not clear it.
REQ-028 Without LFSR_DDS_STICKY_IRQ_EN, the REQ-017 pulse behaviour applies and irq_ack is ignored.

Structure
REQ-029 Package lfsr_dds_pkg shall hold ACC_WIDTH/LFSR_WIDTH defaults, the tap-position constants and the default seed.
REQ-030 Sub-module lfsr_dds_phase_acc shall contain the accumulator and carry/tick generation; lfsr_dds_gen shall instantiate it and hold the LFSR and interrupt logic.

Verification
REQ-031 Reset, enable=1, inc=0x40000000, seed untouched: the interrupt pulses every 4th cycle; lfsr_val reads 0x2, 0x4, 0x8 after successive ticks.
REQ-032 inc=0xFFFFFFFF from reset: no tick on the first cycle, then a tick on every cycle after.
REQ-033 Load seed 0: lfsr_val=0x1; load seed 0x300000 then tick: lfsr_val=0x200000 (fb=0).
REQ-034 Seed load coincident with a tick: lfsr_val equals the seed and the interrupt stays low; inc=0 for 1000 cycles: no interrupt.
REQ-035 Assert reset mid-run (acc non-zero, LFSR=0x1234): acc=0, lfsr_val=0x1 and interrupt=0 immediately, before the next clock edge.
REQ-036 With LFSR_DDS_STICKY_IRQ_EN: a tick with no ack keeps the interrupt high for 20 cycles; one irq_ack cycle returns it low on the next edge; a tick coinciding with irq_ack keeps it high.
